seq_cla_adder: RTL and testbench
================================

# seq_cla_adder

Multi-cycle carry-lookahead adder/subtractor: consumes one 4-bit group per clock, forming group generate/propagate and sum, and chaining the group carry into the next group. It is the ALU datapath's area-reduced adder, sitting between the decode stage's operand registers and the writeback mux. Valid/ready handshakes are used on both the operand and the result side.

## Interface
- WIDTH, 32, operand width; must be a multiple of 4 and at least 8
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start_valid  input  1  operands presented
- start_ready  output  1  block idle and able to accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = A − B, 0 = A + B
- result_valid  output  1  result held stable
- result_ready  input  1  consumer takes result
- sum  output  WIDTH  result
- carry_out  output  1  carry out of the MSB (for subtract, 1 = no borrow)
- overflow  output  1  signed overflow (flag option)
- zero  output  1  sum == 0 (flag option)

## Operation
- FSM states and transitions:
  - IDLE → RUN on start_valid && start_ready.
  - RUN → DONE after group N−1 is processed, where N = WIDTH/4.
  - DONE → IDLE on result_ready.
- start_ready = (state == IDLE). result_valid = (state == DONE).
- On acceptance:
  - Latch a_r = a and b_r = sub ? ~b : b.
  - Set carry register c = sub. Clear group counter k and the sum register.
- Each RUN cycle processes group k, bits [4k+3:4k]:
  - Per bit: g_i = a_i & b_i, p_i = a_i | b_i.
  - G = g3 | p3g2 | p3p2g1 | p3p2p1g0. P = p3p2p1p0.
  - Next carry c ← G | (P & c).
  - Sum bits: s_i = a_i ^ b_i ^ c_i, where c_i is the ripple within the group, starting from the registered c.
  - Write s into sum[4k+3:4k], then k ← k + 1.
- Group N−1 additionally captures:
  - carry_out = group carry.
  - overflow = carry into bit WIDTH−1 XOR carry_out.
  - zero = (final sum == 0).
- sum and all flags hold their value in DONE and IDLE until the next acceptance.
- start_valid outside IDLE is ignored. Operand inputs are sampled only on the acceptance edge.
- Counter k is $clog2(N) bits wide. It wraps to 0 at the transition to DONE and is never read outside RUN.
- Reset, including a reset asserted mid-RUN or in DONE:
  - state = IDLE, k = 0, c = 0.
  - sum = 0, carry_out = 0, overflow = 0, zero = 0.
  - result_valid = 0, start_ready = 1 as soon as reset deasserts.
  - Any in-flight operation is discarded.

## Timing
- Acceptance edge E0. Group k is processed on edge E0+1+k.
- State enters DONE on edge E0+N, so result_valid is high from E0+N (N = 8 at WIDTH=32).
- The result handshake takes effect on the edge where result_valid && result_ready. If result_ready is already high on entry to DONE, DONE lasts exactly one cycle.
- Minimum initiation interval is N+1 cycles, because start_ready is low in DONE. There is no combinational path from start_valid or result_ready to any output.

## Configuration
- SEQ_CLA_FLAGS_EN
  - Defined: overflow and zero are computed as above.
  - Undefined: overflow and zero are tied to 0, and their registers and the zero-detect logic are not built.
  - carry_out is always present.

## Structure
- Shared package alu_pkg holds:
  - State enum {IDLE, RUN, DONE}.
  - GROUP_W = 4.
  - The function that computes N from WIDTH.
- One sub-module, cla_group_4bit: combinational, 4-bit a/b plus carry in → 4-bit sum, group G, group P, carry out, and carry into bit 3. It is instantiated once and steered by k.

## Test plan
- Add 0xFFFFFFFF + 0x00000001 → sum 0x00000000, carry_out 1, zero 1, overflow 0; result_valid exactly 8 cycles after acceptance.
- Add 0x7FFFFFFF + 0x00000001 → sum 0x80000000, carry_out 0, overflow 1, zero 0.
- Subtract 5 − 7 → sum 0xFFFFFFFE, carry_out 0, overflow 0. Subtract 7 − 5 → sum 0x00000002, carry_out 1.
- Hold result_ready low 5 cycles → result_valid and sum stable throughout; start_valid pulses meanwhile are ignored (start_ready 0); a new operation is accepted the cycle after the handshake.
- Assert reset at RUN cycle 3 of 0x12345678 + 0x11111111 → all outputs 0, start_ready 1. A following add 0x12345678 + 0x11111111 completes with sum 0x23456789.
- Build without SEQ_CLA_FLAGS_EN, add 0x7FFFFFFF + 1 → overflow 0, zero 0, sum 0x80000000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, CLA group width and group-count helper.
package alu_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int groups_of(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group_4bit.sv
// Combinational 4-bit carry-lookahead group: sum, group generate/propagate,
// carry out and the carry into bit 3 (for signed-overflow detection).
import alu_pkg::*;

module cla_group_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       g_grp,
  output logic       p_grp,
  output logic       co,
  output logic       c3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a & b;
  assign w_p = a | b;

  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);

  assign g_grp = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign p_grp = &w_p;

  assign s  = a ^ b ^ w_c;
  assign co = g_grp | (p_grp & ci);
  assign c3 = w_c[3];

endmodule

// File: rtl/seq_cla_adder.sv
// Multi-cycle adder/subtractor: one 4-bit CLA group per clock, carry chained in r_c.
// Optional overflow/zero flags built only when SEQ_CLA_FLAGS_EN is defined.
import alu_pkg::*;

module seq_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = groups_of(WIDTH);
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if ((WIDTH % GROUP_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("seq_cla_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic             r_c;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_ga;
  logic [3:0]       w_gb;
  logic [3:0]       w_gs;
  logic             w_gg;
  logic             w_gp;
  logic             w_gcarry;
  logic             w_unused_co;

  assign w_accept = start_valid && (r_state == IDLE);
  assign w_last   = (r_k == K_LAST);
  assign w_ga     = r_a[r_k*GROUP_W +: GROUP_W];
  assign w_gb     = r_b[r_k*GROUP_W +: GROUP_W];
  assign w_gcarry = w_gg | (w_gp & r_c);

`ifdef SEQ_CLA_FLAGS_EN
  logic w_c3;
`else
  logic w_unused_c3;
`endif

  cla_group_4bit u_group (
    .a     (w_ga),
    .b     (w_gb),
    .ci    (r_c),
    .s     (w_gs),
    .g_grp (w_gg),
    .p_grp (w_gp),
    .co    (w_unused_co),
`ifdef SEQ_CLA_FLAGS_EN
    .c3    (w_c3)
`else
    .c3    (w_unused_c3)
`endif
  );

  // Operand registers carry no reset: only loaded on acceptance, never read before it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= sub ? ~b : b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_state <= RUN;
            r_k     <= '0;
            r_c     <= sub;
            r_sum   <= '0;
          end
        end
        RUN: begin
          r_sum[r_k*GROUP_W +: GROUP_W] <= w_gs;
          r_c <= w_gcarry;
          if (w_last) begin
            r_k     <= '0;
            r_cout  <= w_gcarry;
            r_state <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (result_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_CLA_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf  <= w_c3 ^ w_gcarry;
      r_zero <= (w_gs == 4'd0) && (r_sum[WIDTH-GROUP_W-1:0] == '0);
    end
  end

  assign overflow = r_ovf;
  assign zero     = r_zero;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  assign start_ready  = (r_state == IDLE);
  assign result_valid = (r_state == DONE);
  assign sum          = r_sum;
  assign carry_out    = r_cout;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Scoreboard bench for seq_cla_adder; flag expectations follow SEQ_CLA_FLAGS_EN.
`timescale 1ns/1ps

module tb_seq_cla_adder;

  localparam int WIDTH = 32;
  localparam int NGRP  = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    logic             z;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_cla_adder #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .sub          (sub),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .carry_out    (carry_out),
    .overflow     (overflow),
    .zero         (zero)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s_op);
    exp_t e;
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   full;
    yy   = s_op ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, s_op};
    e.s  = full[WIDTH-1:0];
    e.co = full[WIDTH];
`ifdef SEQ_CLA_FLAGS_EN
    e.ov = (x[WIDTH-1] == yy[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
    e.z  = (e.s == '0);
`else
    e.ov = 1'b0;
    e.z  = 1'b0;
`endif
    return e;
  endfunction

  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s_op);
    @(negedge clk);
    a = x; b = y; sub = s_op; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = $urandom; b = $urandom; sub = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s_op, input int hold);
    exp_t e;
    int   cyc;
    accept(x, y, s_op);
    sb.push_back(model(x, y, s_op));
    chk("start_ready_in_run", start_ready, 0);
    cyc = 0;
    while (!result_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, NGRP);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      chk("hold_valid", result_valid, 1);
      chk("hold_sum", sum, e.s);
      chk("hold_start_ready", start_ready, 0);
    end
    chk("sum", sum, e.s);
    chk("carry_out", carry_out, e.co);
    chk("overflow", overflow, e.ov);
    chk("zero", zero, e.z);
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    chk("valid_after_hs", result_valid, 0);
    chk("ready_after_hs", start_ready, 1);
    chk("sum_held_idle", sum, e.s);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry_out", carry_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 5);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0);

    // Reset in the middle of RUN discards the operation.
    accept(32'h1234_5678, 32'h1111_1111, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_start_ready", start_ready, 1);
    chk("midrun_result_valid", result_valid, 0);
    chk("midrun_sum", sum, 0);
    chk("midrun_carry_out", carry_out, 0);
    chk("midrun_overflow", overflow, 0);
    chk("midrun_zero", zero, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_start_ready", start_ready, 1);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), i % 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
